// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line refill/writeback responder backed by a word-addressed store.
// Reads stream BEATS words after LATENCY cycles; writes acknowledge with a done pulse LATENCY cycles after the last beat.
module line_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BEATS       = 4,
  parameter int LATENCY     = 8,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              wdata_valid_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wdata_ready_o,
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_last_o,
  output logic              wr_done_o,
  output logic              busy_o
);
  localparam int BW = $clog2(BEATS);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;
  typedef enum logic [2:0] {IDLE, RWAIT, RBURST, WBURST, WWAIT} state_t;
  state_t            r_state, w_next;
  logic [AW-BW-1:0]  r_line;
  logic [BW-1:0]     r_beat;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS] = '{default: '0};
  logic [AW-1:0]     w_addr;
  logic              w_lat_done, w_emit, w_wr, w_unused;
  // word index wraps naturally because only the in-range line bits are kept
  assign w_addr        = {r_line, r_beat};
  assign w_lat_done    = r_cnt == CW'(LATENCY - 1);
  assign w_emit        = (r_state == RWAIT && w_lat_done) || (r_state == RBURST && !rdata_last_o);
  assign w_wr          = r_state == WBURST && wdata_valid_i;
  assign req_ready_o   = r_state == IDLE;
  assign busy_o        = r_state != IDLE;
  assign wdata_ready_o = r_state == WBURST;
  assign w_unused      = ^{req_addr_i[ADDR_W-1:AW+2], req_addr_i[BW+1:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_next = req_we_i ? WBURST : RWAIT;
      RWAIT:   if (w_lat_done) w_next = RBURST;
      RBURST:  if (rdata_last_o) w_next = IDLE;
      WBURST:  if (w_wr && r_beat == BW'(BEATS - 1)) w_next = WWAIT;
      WWAIT:   if (w_lat_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_line        <= '0;
      r_beat        <= '0;
      r_cnt         <= '0;
      rdata_valid_o <= 1'b0;
      rdata_last_o  <= 1'b0;
      rdata_o       <= '0;
      wr_done_o     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= (r_state == RWAIT || r_state == WWAIT) ? r_cnt + 1'b1 : '0;
      r_beat        <= (r_state == IDLE) ? '0 : (w_emit || w_wr) ? r_beat + 1'b1 : r_beat;
      if (r_state == IDLE && req_valid_i) r_line <= req_addr_i[AW+1:BW+2];
      rdata_valid_o <= w_emit;
      rdata_last_o  <= w_emit && r_beat == BW'(BEATS - 1);
      if (w_emit) rdata_o <= r_mem[w_addr];
      wr_done_o     <= r_state == WWAIT && w_lat_done;
    end
  end
  // store is deliberately outside the reset domain; writes stop as soon as reset is seen
  always_ff @(posedge clk) begin
    if (w_wr && !rst) r_mem[w_addr] <= wdata_i;
  end
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: scoreboard bench driving a LATENCY=8 and a LATENCY=1 responder with shared stimulus.
// Expected beats and done pulses are queued with their due cycle; a negedge monitor pops and compares.
module tb_line_mem_responder;
  localparam int BEATS = 4;
  localparam int DEPTH = 1024;
  typedef struct {
    int          inst;
    int          kind;
    longint      t;
    logic [31:0] data;
    logic        last;
  } ev_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, wdata_valid = 1'b0;
  logic [31:0] req_addr = '0, wdata = '0;
  logic        req_ready [2], wdata_ready [2], rvalid [2], rlast [2], done [2], busy [2];
  logic [31:0] rdata [2];
  logic [31:0] model [DEPTH];
  logic [31:0] wd [4];
  int          gp [4];
  ev_t         sb [$];
  longint      cyc = 0, e0, ef;
  int          tests = 0, fails = 0;

  line_mem_responder #(.LATENCY(8)) u0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_we_i(req_we),
    .req_addr_i(req_addr), .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready[0]),
    .rdata_valid_o(rvalid[0]), .rdata_o(rdata[0]), .rdata_last_o(rlast[0]), .wr_done_o(done[0]), .busy_o(busy[0]));
  line_mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_we_i(req_we),
    .req_addr_i(req_addr), .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready[1]),
    .rdata_valid_o(rvalid[1]), .rdata_o(rdata[1]), .rdata_last_o(rlast[1]), .wr_done_o(done[1]), .busy_o(busy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    return i == 0 ? 8 : 1;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void match(input int i, input int k, input logic [31:0] d, input logic l);
    int j = -1;
    foreach (sb[x]) if (j < 0 && sb[x].inst == i && sb[x].kind == k) j = x;
    if (j < 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s inst%0d: got data %h last %0b, none expected (cycle %0d)", k ? "done" : "beat", i, d, l, cyc);
    end else begin
      chk($sformatf("%s_inst%0d {cycle,last,data}", k ? "done" : "beat", i), {cyc[30:0], l, d},
          {sb[j].t[30:0], sb[j].last, sb[j].data});
      sb.delete(j);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rvalid[i] === 1'b1) match(i, 0, rdata[i], rlast[i]);
      if (done[i] === 1'b1) match(i, 1, '0, 1'b0);
    end
  end

  function automatic int widx(input logic [31:0] a, input int k);
    return int'((((a >> 2) / BEATS) * BEATS + k) % DEPTH);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready[0] && req_ready[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: responders still busy after %0d cycles", n);
    end
  endtask

  task automatic start_read(input logic [31:0] a);
    wait_idle();
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = a;
    e0 = cyc + 1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < BEATS; k++)
        sb.push_back('{i, 0, e0 + lat(i) + k, model[widx(a, k)], k == BEATS - 1});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input bit junk);
    start_read(a);
    if (junk) begin
      wdata_valid = 1'b1;
      wdata = $urandom;
    end
    while (cyc < e0 + 8 + BEATS - 1) @(negedge clk);
    chk("ready_during_last_beat", {63'd0, req_ready[0]}, 64'd0);
    @(negedge clk);
    chk("ready_after_burst", {63'd0, req_ready[0]}, 64'd1);
    wdata_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input bit spurious);
    wait_idle();
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = a;
    @(negedge clk);
    req_valid = spurious;
    req_we = 1'b0;
    req_addr = a ^ 32'h100;
    for (int k = 0; k < BEATS; k++) begin
      repeat (gp[k]) begin
        wdata_valid = 1'b0;
        wdata = $urandom;
        @(negedge clk);
      end
      wdata_valid = 1'b1;
      wdata = wd[k];
      chk("wdata_ready", {63'd0, wdata_ready[0]}, 64'd1);
      if (spurious) chk("ignored_req_ready", {63'd0, req_ready[0]}, 64'd0);
      @(negedge clk);
    end
    ef = cyc;
    wdata_valid = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) sb.push_back('{i, 1, ef + lat(i), '0, 1'b0});
    for (int k = 0; k < BEATS; k++) model[widx(a, k)] = wd[k];
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", {63'd0, req_ready[i]}, 64'd1);
      chk("reset_idle_outputs", {59'd0, busy[i], rvalid[i], rlast[i], done[i], wdata_ready[i]}, 64'd0);
      chk("reset_rdata", {32'd0, rdata[i]}, 64'd0);
    end
    do_read(32'h40, 1'b0);
    wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    gp = '{0, 0, 0, 0};
    do_write(32'h40, 1'b0);
    do_read(32'h40, 1'b0);
    do_read(32'h4C, 1'b1);
    wd = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    gp = '{0, 1, 0, 2};
    do_write(32'h80, 1'b1);
    do_read(32'h80, 1'b0);
    start_read(32'h40);
    while (cyc < e0 + 8 + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].t >= cyc) sb.delete(j);
    rst = 1'b0;
    chk("midreset_outputs {valid,busy,ready}", {61'd0, rvalid[0], busy[0], req_ready[0]}, 64'd1);
    do_read(32'h40, 1'b0);
    do_read(DEPTH * 4 + 32'h40, 1'b0);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 3) * DEPTH * 4 + ($urandom_range(0, 15) << 4) + $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BEATS; k++) begin
          wd[k] = $urandom;
          gp[k] = $urandom_range(0, 3);
        end
        do_write(a, 1'($urandom_range(0, 1)));
      end else do_read(a, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (12) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
Memory-side responder for the cache miss path. It accepts line refill (read) and line writeback (write) requests from the cache controller and holds a word-addressed backing store. Each request is serviced after a fixed access latency. Read lines are streamed back as consecutive data beats; write lines are acknowledged with a done pulse. It stands in for main memory below the L1/L2/L3 hierarchy.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, beat/word width
BEATS, 4, words per cache line (power of 2, >=2)
LATENCY, 8, access latency in cycles (>=1)
DEPTH_WORDS, 1024, backing store size in words (power of 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  responder can accept a request
req_we_i  in  1  1=line write (writeback), 0=line read (refill)
req_addr_i  in  ADDR_W  byte address of the line
wdata_valid_i  in  1  write beat valid
wdata_i  in  DATA_W  write beat data
wdata_ready_o  out  1  write beat accepted this cycle when valid
rdata_valid_o  out  1  read beat valid
rdata_o  out  DATA_W  read beat data
rdata_last_o  out  1  final beat of line
wr_done_o  out  1  one-cycle write completion pulse
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; counters 0; rdata_valid_o, rdata_last_o, wr_done_o, wdata_ready_o = 0; rdata_o = 0. Reset does not clear the backing store. The store is zero-initialised at time 0.
- req_ready_o = (state==IDLE). The handshake completes on a clock edge where req_valid_i & req_ready_o. Address and we are latched at that edge.
- Line base: the low log2(BEATS)+2 address bits are ignored, so unaligned addresses map to their line. Word index = (line_base>>2 + beat) mod DEPTH_WORDS, which wraps silently.
- FSM states: IDLE, RWAIT, RBURST, WBURST, WWAIT.
- IDLE -> RWAIT on a read handshake; IDLE -> WBURST on a write handshake.
- RWAIT: count LATENCY-1 further edges, then -> RBURST. The first beat is registered on edge E0+LATENCY, where E0 is the handshake edge.
- RBURST: beats 0..BEATS-1 are presented on consecutive cycles with no backpressure. rdata_last_o is high only with beat BEATS-1. After the last beat: -> IDLE, and req_ready_o is high in the following cycle.
- WBURST: wdata_ready_o = 1 (combinational on state). A beat is written when wdata_valid_i=1. Gaps are allowed. Beats are stored in order 0..BEATS-1. The final beat moves the FSM -> WWAIT.
- WWAIT: LATENCY cycles after the final-beat edge, wr_done_o pulses for one cycle; the FSM enters IDLE on the same edge.
- A read issued after wr_done_o returns the newly written data.
- req_valid_i while busy is ignored and not queued. wdata_valid_i outside WBURST is ignored.
- Reset mid-operation: an in-flight burst is abandoned immediately and all outputs clear next cycle. Beats already written stay in the store.
- No pipelining: one outstanding request at a time.

Test Plan:
- After reset, read 0x40 (LATENCY=8, handshake at edge 0) -> rdata_valid_o at edges 8..11, data 0,0,0,0, last at edge 11; req_ready_o high after edge 12.
- Write 0x40 with beats 0x11,0x22,0x33,0x44, then read 0x40 -> wr_done_o exactly 8 cycles after the 4th beat; read returns 0x11,0x22,0x33,0x44 in order.
- Unaligned read 0x4C after the previous write -> returns the same line 0x11..0x44 starting at beat 0.
- Write with wdata_valid_i gaps (beats on cycles 1,3,4,7) -> all 4 stored; wr_done_o 8 cycles after cycle 7; a second req_valid_i during the burst is ignored (req_ready_o=0).
- Assert rst during beat 2 of a read burst -> next cycle rdata_valid_o=0, busy_o=0, req_ready_o=1; a subsequent read returns the correct data.
- LATENCY=1, address DEPTH_WORDS*4+0x40 -> wraps to 0x40 data; first beat on the edge after the handshake.
